// File: rtl/cmp_pkg.sv
// Shared constants for the streaming comparator: one-hot result bit positions
// and default sizing.
package cmp_pkg;
    localparam int CMP_LT        = 0;
    localparam int CMP_EQ        = 1;
    localparam int CMP_GT        = 2;
    localparam int CMP_N_DEF     = 10;
    localparam int CMP_CNT_W_DEF = 16;
endpackage

// File: rtl/comparator_nbit_core.sv
// Combinational N-bit magnitude compare, unsigned or two's-complement,
// producing a one-hot {greater, equal, smaller} vector.
module comparator_nbit_core
    import cmp_pkg::*;
#(
    parameter int N = CMP_N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         signed_mode,
    output logic [2:0]   res
);
    logic lt;
    logic eq;

    always_comb begin
        lt          = signed_mode ? ($signed(a) < $signed(b)) : (a < b);
        eq          = (a == b);
        res         = '0;
        res[CMP_LT] = lt;
        res[CMP_EQ] = eq;
        res[CMP_GT] = !lt && !eq;
    end
endmodule

// File: rtl/comparator_nbit_stream.sv
// Registered valid/ready comparator with saturating per-outcome counters.
// Define CMP_MINMAX_EN to add running unsigned min/max of operand A.
module comparator_nbit_stream
    import cmp_pkg::*;
#(
    parameter int N     = CMP_N_DEF,
    parameter int CNT_W = CMP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             signed_mode,
    input  logic             clr_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             smaller,
    output logic             equal,
    output logic             greater,
    output logic [CNT_W-1:0] cnt_smaller,
    output logic [CNT_W-1:0] cnt_equal,
    output logic [CNT_W-1:0] cnt_greater
`ifdef CMP_MINMAX_EN
    ,
    output logic [N-1:0]     min_a,
    output logic [N-1:0]     max_a
`endif
);
    logic                       out_valid_q, out_valid_d;
    logic [2:0]                 res_q, res_d;
    logic [2:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]                 core_res;
    logic                       in_xfer;
    logic                       out_xfer;

    comparator_nbit_core #(.N(N)) u_core (
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .res         (core_res)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // core_res is only consumed behind in_xfer, so X operands on idle cycles never land in state
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            res_d       = core_res;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
            res_d       = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (clr_cnt)
                cnt_d[i] = '0;
            if (in_xfer && core_res[i] && !(&cnt_d[i]))
                cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign smaller     = res_q[CMP_LT];
    assign equal       = res_q[CMP_EQ];
    assign greater     = res_q[CMP_GT];
    assign cnt_smaller = cnt_q[CMP_LT];
    assign cnt_equal   = cnt_q[CMP_EQ];
    assign cnt_greater = cnt_q[CMP_GT];

`ifdef CMP_MINMAX_EN
    logic [N-1:0] min_q, min_d, max_q, max_d;

    // clr_cnt restarts the window, so a coincident sample becomes the new min and max
    always_comb begin
        min_d = clr_cnt ? {N{1'b1}} : min_q;
        max_d = clr_cnt ? '0 : max_q;
        if (in_xfer) begin
            if (a < min_d) min_d = a;
            if (a > max_d) max_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= {N{1'b1}};
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_a = min_q;
    assign max_a = max_q;
`endif
endmodule

// File: tb/tb_comparator_nbit_stream.sv
// Self-checking bench for comparator_nbit_stream (N=10, CNT_W=4): directed
// cases followed by randomized traffic against a transaction-level model.
module tb_comparator_nbit_stream;
    localparam int N     = 10;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, in_valid, signed_mode, clr_cnt, out_ready;
    logic [N-1:0]     a, b;
    logic             in_ready, out_valid, smaller, equal, greater;
    logic [CNT_W-1:0] cnt_smaller, cnt_equal, cnt_greater;
`ifdef CMP_MINMAX_EN
    logic [N-1:0]     min_a, max_a;
`endif

    comparator_nbit_stream #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .clr_cnt     (clr_cnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .smaller     (smaller),
        .equal       (equal),
        .greater     (greater),
        .cnt_smaller (cnt_smaller),
        .cnt_equal   (cnt_equal),
        .cnt_greater (cnt_greater)
`ifdef CMP_MINMAX_EN
        ,
        .min_a       (min_a),
        .max_a       (max_a)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: outcome index 0 = A<B, 1 = A==B, 2 = A>B
    bit m_valid;
    int m_out;
    int m_cnt[3];
    int m_min, m_max;

    function automatic int outcome(input logic [N-1:0] x, input logic [N-1:0] y, input bit s);
        int vx, vy;
        vx = int'(x);
        vy = int'(y);
        if (s) begin
            if (vx >= (1 << (N-1))) vx -= (1 << N);
            if (vy >= (1 << (N-1))) vy -= (1 << N);
        end
        if (vx < vy) return 0;
        if (vx == vy) return 1;
        return 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = -1;
        m_cnt   = '{0, 0, 0};
        m_min   = (1 << N) - 1;
        m_max   = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("smaller",   32'(smaller),   32'(m_valid && m_out == 0));
        chk("equal",     32'(equal),     32'(m_valid && m_out == 1));
        chk("greater",   32'(greater),   32'(m_valid && m_out == 2));
        chk("cnt_smaller", 32'(cnt_smaller), 32'(m_cnt[0]));
        chk("cnt_equal",   32'(cnt_equal),   32'(m_cnt[1]));
        chk("cnt_greater", 32'(cnt_greater), 32'(m_cnt[2]));
`ifdef CMP_MINMAX_EN
        chk("min_a", 32'(min_a), 32'(m_min));
        chk("max_a", 32'(max_a), 32'(m_max));
`endif
    endtask

    // One clock: drive after negedge, check ready, update model at posedge, check 1 time unit later.
    task automatic step(input bit r, input bit iv, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input bit s, input bit ordy, input bit cl);
        bit in_x, out_x;
        int o;
        @(negedge clk);
        reset = r; in_valid = iv; a = ta; b = tb_v; signed_mode = s; out_ready = ordy; clr_cnt = cl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        in_x = iv && (!m_valid || ordy);
        out_x = m_valid && ordy;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (cl) begin
                m_cnt = '{0, 0, 0};
                m_min = (1 << N) - 1;
                m_max = 0;
            end
            if (in_x) begin
                o = outcome(ta, tb_v, s);
                m_valid = 1'b1;
                m_out = o;
                m_cnt[o] = (m_cnt[o] + 1 > CMAX) ? CMAX : m_cnt[o] + 1;
                if (int'(ta) < m_min) m_min = int'(ta);
                if (int'(ta) > m_max) m_max = int'(ta);
            end else if (out_x) begin
                m_valid = 1'b0;
                m_out = -1;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        out_ready = 1'b1; clr_cnt = 1'b0;
        model_reset();

        // reset
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", 32'({greater, equal, smaller}), 32'd0);

        // unsigned compares, back to back
        step(0, 1, 10'd5,   10'd99, 0, 1, 0);
        chk("u_lt", 32'(smaller), 32'd1);
        step(0, 1, 10'd66,  10'd66, 0, 1, 0);
        chk("u_eq", 32'(equal), 32'd1);
        step(0, 1, 10'd100, 10'd47, 0, 1, 0);
        chk("u_gt", 32'(greater), 32'd1);
        step(0, 0, 'x, 'x, 0, 1, 0);
        chk("cnt_111", 32'({cnt_smaller, cnt_equal, cnt_greater}), 32'h111);

        // signed vs unsigned with identical operands
        step(0, 1, 10'h3FF, 10'd1, 1, 1, 0);
        chk("s_lt", 32'(smaller), 32'd1);
        step(0, 1, 10'h3FF, 10'd1, 0, 1, 0);
        chk("u_gt2", 32'(greater), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);

        // backpressure: hold result for 5 cycles, then accept pending input
        step(0, 1, 10'd1, 10'd2, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 10'd9, 10'd3, 0, 0, 0);
            chk("bp_hold", 32'({out_valid, smaller, in_ready}), 32'b110);
        end
        step(0, 1, 10'd9, 10'd3, 0, 1, 0);
        chk("bp_next", 32'(greater), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);

        // saturation, then clear coinciding with a greater transfer
        for (int i = 0; i < 20; i++) step(0, 1, 10'd7, 10'd7, 0, 1, 0);
        chk("sat_eq", 32'(cnt_equal), 32'd15);
        step(0, 1, 10'd200, 10'd3, 0, 1, 1);
        chk("clr_xfer", 32'({cnt_smaller, cnt_equal, cnt_greater}), 32'h001);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("clr_only", 32'({cnt_smaller, cnt_equal, cnt_greater}), 32'h000);

`ifdef CMP_MINMAX_EN
        step(0, 1, 10'd300, 10'd0, 0, 1, 0);
        step(0, 1, 10'd7,   10'd0, 0, 1, 0);
        step(0, 1, 10'd512, 10'd0, 0, 1, 0);
        chk("mm_min", 32'(min_a), 32'd7);
        chk("mm_max", 32'(max_a), 32'd512);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("mm_clr", 32'({min_a, max_a}), 32'({10'h3FF, 10'h000}));
`endif

        // reset while a result is held
        step(0, 1, 10'd1, 10'd9, 0, 0, 0);
        step(0, 1, 10'd1, 10'd9, 0, 0, 1);
        step(1, 1, 10'd1, 10'd9, 0, 1, 1);
        chk("mid_rst", 32'(out_valid), 32'd0);

        // randomized traffic, X operands on idle cycles
        for (int i = 0; i < 400; i++) begin
            bit iv, ordy, cl, s, r;
            logic [N-1:0] ra, rb;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            cl   = ($urandom_range(0, 15) == 0);
            r    = ($urandom_range(0, 99) == 0);
            s    = 1'(($urandom_range(0, 1)));
            ra   = N'($urandom_range(0, (1 << N) - 1));
            rb   = ($urandom_range(0, 3) == 0) ? ra : N'($urandom_range(0, (1 << N) - 1));
            if (!iv && $urandom_range(0, 1) == 1) begin
                ra = 'x;
                rb = 'x;
            end
            step(r, iv, ra, rb, s, ordy, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
